// File: rtl/mod_shift_preproc.sv
// mod_shift_preproc: bit-serial Montgomery pre-processing, R = M*2^K mod N.
// Optional n==0 detection is enabled by defining MOD_SHIFT_NZERO_CHK_EN.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, m, n, k    job request and operands, sampled when busy=0
//   busy              job in flight (RUN or DONE)
//   out_valid         result/err valid, held until out_ready
//   out_ready         consumer accepts result
//   result            M*2^K mod N
//   err               n==0 flag (tied low unless MOD_SHIFT_NZERO_CHK_EN)
module mod_shift_preproc #(
    parameter int WIDTH = 256,
    parameter int KW    = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] n,
    input  logic [KW-1:0]    k,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int STEPS_MAX = WIDTH + (1 << KW) - 1;
    localparam int CW        = $clog2(STEPS_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] m_sh;
    logic [WIDTH-1:0] n_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH:0]   t;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    last;
    logic             nzero;

`ifdef MOD_SHIFT_NZERO_CHK_EN
    assign nzero = (n == '0);
`else
    assign nzero = 1'b0;
`endif

    // M is fed MSB first by shifting; once all WIDTH bits are consumed the
    // register holds zero, which supplies the b=0 bits of the doubling phase.
    // R < N < 2^WIDTH, so R fits in WIDTH bits and only T needs the extra bit.
    assign t     = {r, m_sh[WIDTH-1]};
    assign r_nxt = WIDTH'((t >= {1'b0, n_q}) ? t - {1'b0, n_q} : t);
    assign last  = CW'(WIDTH) + CW'(k_q) - CW'(1);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        out_valid = 1'b0;
        result    = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = nzero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                result    = r;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            m_sh  <= '0;
            n_q   <= '0;
            k_q   <= '0;
            r     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                m_sh <= m;
                n_q  <= n;
                k_q  <= k;
                r    <= '0;
                cnt  <= '0;
            end else if (state == RUN) begin
                m_sh <= m_sh << 1;
                r    <= r_nxt;
                cnt  <= cnt + CW'(1);
            end
        end
    end

`ifdef MOD_SHIFT_NZERO_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            err_q <= nzero;
        end else if (state == DONE && out_ready) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
